mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Request-side controller that sits directly upstream of the `ram` block and drives its `data`/`addr`/`wr` inputs. It converts a valid/ready request stream from the core into `ram`'s change-detect protocol and returns read data with a valid/ready response. The `ram` block signals start and finish by dropping and raising `response` on negedges. `mem_ctrl` hides that protocol, including the identical-request case, where `response` never drops.

## Interface
Parameters:
- `RAM_SIZE`, 1024: word count of the attached `ram`; must match its `size`.
- `TIMEOUT_CYCLES`, 64: watchdog limit in cycles. Only used with `MEM_CTRL_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock, posedge logic (`ram` uses the negedge of the same clock).
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request.
- `req_wr`  in  1  1 = write, 0 = read.
- `req_addr`  in  32  word address.
- `req_wdata`  in  32  write data.
- `rsp_valid`  out  1  response present; held until `rsp_ready`.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_rdata`  out  32  read data; 0 for writes and errors.
- `rsp_err`  out  1  address out of range, or timeout.
- `ram_data`  out  32  to `ram.data`.
- `ram_addr`  out  32  to `ram.addr`.
- `ram_wr`  out  1  to `ram.wr`.
- `ram_response`  in  1  from `ram.response`.
- `ram_out`  in  32  from `ram.out`.

## Operation
- FSM states: SYNC, IDLE, WAIT_LOW, WAIT_HIGH, SAME, RESP.
- **SYNC**
  - Entered on reset and after a timeout.
  - Waits 2 cycles, then waits for `ram_response`=1.
  - Then moves to IDLE.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid & req_ready`, registers the request.
- **Out-of-range request** (`req_addr >= RAM_SIZE`)
  - Goes straight to RESP with `rsp_err`=1 and `rsp_rdata`=0.
  - The `ram_*` outputs are not touched.
- **Request differs from current `ram_*` drive** (any of addr, data or wr)
  - Drives the new values onto `ram_*`, then goes to WAIT_LOW.
  - WAIT_LOW exits on `ram_response`=0 and goes to WAIT_HIGH.
  - WAIT_HIGH exits on `ram_response`=1 and goes to RESP.
- **Request identical to current drive**
  - Goes to SAME.
  - SAME holds 2 cycles, which guarantees at least one executing negedge, then goes to RESP.
- **Read data capture**
  - On leaving WAIT_HIGH or SAME for a read, `rsp_rdata` is loaded from `ram_out`.
  - For a write, `rsp_rdata` is loaded with 0.
- **RESP**
  - `rsp_valid`=1 until `rsp_ready`, then returns to IDLE.
- **Drive hold**
  - `ram_*` outputs hold their last values between requests, so the change-detector is not retriggered.
- **Write address for `ram`**
  - `req_wdata` is ignored for reads, but `ram_data` is still compared and driven. This keeps `ram`'s change-detector consistent.

## Timing
- **Reset values:**
  - `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
  - `ram_data`=0, `ram_addr`=0, `ram_wr`=0.
  - State = SYNC.
- **Accept and drive:** accept at posedge N; `ram_*` are updated at posedge N.
- **Changed request latency:**
  - `ram` drops `response` at negedge N+½ and executes at negedge N+1½.
  - `mem_ctrl` sees low at N+1 and high at N+2.
  - `rsp_valid` rises after posedge N+2: 2-cycle latency.
- **Identical request:** also 2 cycles.
- **Out-of-range request:** `rsp_valid` after posedge N+1: 1 cycle.
- **Throughput:** no request is accepted while `rsp_valid`=1. One request is outstanding at most.
- **Reset mid-operation:**
  - The FSM goes to SYNC and drives are zeroed.
  - The `ram` contents are whatever the completed negedges wrote.
  - Any in-flight response is discarded.

## Configuration
- `MEM_CTRL_TIMEOUT_EN` defined:
  - A counter runs in WAIT_LOW and WAIT_HIGH.
  - On reaching `TIMEOUT_CYCLES`, the FSM goes to RESP with `rsp_err`=1, then goes to SYNC instead of IDLE.
- `MEM_CTRL_TIMEOUT_EN` not defined:
  - No counter; waits are unbounded.
  - `TIMEOUT_CYCLES` is unused.

## Structure
- Package `mem_ctrl_pkg` holds:
  - the state enum `mem_ctrl_state_t`;
  - `RAM_ADDR_W`/`RAM_DATA_W` = 32.
- One sub-module, `mem_ctrl_watchdog`: the counter with clear, enable and expired signals. It is only instantiated under `MEM_CTRL_TIMEOUT_EN`.

## Test plan
- Write 0xDEADBEEF to address 5, then read address 5 → the read returns `rsp_rdata`=0xDEADBEEF with `rsp_err`=0; each request has 2-cycle latency.
- Read address 5 twice back-to-back (identical request) → the second read completes via SAME in 2 cycles with 0xDEADBEEF.
- Read address 1024 with `RAM_SIZE`=1024 → `rsp_err`=1 and `rsp_rdata`=0 after 1 cycle; `ram_addr` is unchanged.
- Hold `rsp_ready`=0 for 5 cycles → `rsp_valid` and `rsp_rdata` stay stable and `req_ready`=0 throughout.
- Assert `rst` during WAIT_HIGH → all outputs return to their reset values at once; the next request after SYNC completes normally.
- With `MEM_CTRL_TIMEOUT_EN`, tie `ram_response`=1 for a changed request → `rsp_err`=1 after 64 cycles, then the FSM goes to SYNC.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and widths for the mem_ctrl request-side RAM controller.
package mem_ctrl_pkg;

  localparam int unsigned RAM_ADDR_W = 32;
  localparam int unsigned RAM_DATA_W = 32;

  typedef enum logic [2:0] {
    SYNC,
    IDLE,
    WAIT_LOW,
    WAIT_HIGH,
    SAME,
    RESP
  } mem_ctrl_state_t;

  // Everything the ram change-detector looks at.
  typedef struct packed {
    logic                  wr;
    logic [RAM_ADDR_W-1:0] addr;
    logic [RAM_DATA_W-1:0] data;
  } ram_req_t;

endpackage

// File: rtl/mem_ctrl_watchdog.sv
// Wait-state watchdog for mem_ctrl; expired_c rises on the LIMIT-th enabled cycle.
module mem_ctrl_watchdog #(
  parameter int unsigned LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CNT_W-1:0] cnt;

  assign expired_c = en && (cnt >= CNT_W'(LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired_c) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Valid/ready front end for the negedge change-detect ram block.
// Optional wait-state watchdog enabled by defining MEM_CTRL_TIMEOUT_EN.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned RAM_SIZE       = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [RAM_ADDR_W-1:0] req_addr,
  input  logic [RAM_DATA_W-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [RAM_DATA_W-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [RAM_DATA_W-1:0] ram_data,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic                  ram_wr,
  input  logic                  ram_response,
  input  logic [RAM_DATA_W-1:0] ram_out
);

  mem_ctrl_state_t state;
  logic [1:0]      sync_cnt;
  logic            same_cnt;
  logic            is_wr;
  logic            to_sync;
  logic            timeout_c;
  logic            oob_c;
  ram_req_t        drive_c;
  ram_req_t        new_c;

  assign oob_c   = (req_addr >= RAM_ADDR_W'(RAM_SIZE));
  assign drive_c = '{wr: ram_wr, addr: ram_addr, data: ram_data};
  assign new_c   = '{wr: req_wr, addr: req_addr, data: req_wdata};

`ifdef MEM_CTRL_TIMEOUT_EN
  mem_ctrl_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clr       (state == IDLE),
    .en        ((state == WAIT_LOW) || (state == WAIT_HIGH)),
    .expired_c (timeout_c)
  );
`else
  logic unused_timeout_c;
  assign unused_timeout_c = ^TIMEOUT_CYCLES;
  assign timeout_c        = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SYNC;
      sync_cnt  <= 2'd0;
      same_cnt  <= 1'b0;
      is_wr     <= 1'b0;
      to_sync   <= 1'b0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      ram_data  <= '0;
      ram_addr  <= '0;
      ram_wr    <= 1'b0;
    end else begin
      case (state)
        SYNC: begin
          if (sync_cnt != 2'd2) begin
            sync_cnt <= sync_cnt + 2'd1;
          end else if (ram_response) begin
            state     <= IDLE;
            req_ready <= 1'b1;
          end
        end

        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            is_wr     <= req_wr;
            if (oob_c) begin
              state <= RESP;
            end else if (new_c != drive_c) begin
              ram_wr   <= req_wr;
              ram_addr <= req_addr;
              ram_data <= req_wdata;
              state    <= WAIT_LOW;
            end else begin
              same_cnt <= 1'b0;
              state    <= SAME;
            end
          end
        end

        WAIT_LOW: begin
          if (!ram_response) begin
            state <= WAIT_HIGH;
          end else if (timeout_c) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            to_sync   <= 1'b1;
          end
        end

        WAIT_HIGH: begin
          if (ram_response) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= is_wr ? '0 : ram_out;
          end else if (timeout_c) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            to_sync   <= 1'b1;
          end
        end

        // Two cycles cover at least one executing negedge of the ram.
        SAME: begin
          if (same_cnt) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= is_wr ? '0 : ram_out;
          end else begin
            same_cnt <= 1'b1;
          end
        end

        // Entered with rsp_valid low only for an out-of-range request.
        RESP: begin
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            if (to_sync) begin
              to_sync  <= 1'b0;
              sync_cnt <= 2'd0;
              state    <= SYNC;
            end else begin
              req_ready <= 1'b1;
              state     <= IDLE;
            end
          end
        end

        default: begin
          state    <= SYNC;
          sync_cnt <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a behavioural negedge change-detect ram.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] ram_data;
  logic [31:0] ram_addr;
  logic        ram_wr;
  logic        ram_response;
  logic [31:0] ram_out;

  int n_checks = 0;
  int n_fails  = 0;

  // Behavioural ram: a changed input drops response; an unchanged one executes.
  logic [31:0] mem [0:1023];
  logic [64:0] last_seen;
  logic        ram_resp_m;
  logic        tie_hi;

  assign ram_response = tie_hi ? 1'b1 : ram_resp_m;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if ({ram_wr, ram_addr, ram_data} != last_seen) begin
      ram_resp_m <= 1'b0;
      last_seen  <= {ram_wr, ram_addr, ram_data};
    end else begin
      if (ram_wr) mem[ram_addr[9:0]] <= ram_data;
      ram_out    <= ram_wr ? ram_data : mem[ram_addr[9:0]];
      ram_resp_m <= 1'b1;
    end
  end

  mem_ctrl #(
    .RAM_SIZE       (1024),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wr       (req_wr),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .ram_data     (ram_data),
    .ram_addr     (ram_addr),
    .ram_wr       (ram_wr),
    .ram_response (ram_response),
    .ram_out      (ram_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!req_ready && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, 32'(req_ready), 32'd1);
  endtask

  task automatic do_req(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int exp_lat,
                        input logic [31:0] exp_rdata, input logic exp_err, input int hold);
    int lat = 0;
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    while (!rsp_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_rdata"}, rsp_rdata, exp_rdata);
    chk({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_hold_rdata"}, rsp_rdata, exp_rdata);
      chk({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    last_seen  = '0;
    ram_resp_m = 1'b1;
    ram_out    = 32'd0;
    tie_hi     = 1'b0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_wr     = 1'b0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    rsp_ready  = 1'b0;

    @(posedge clk); #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_ram_addr", ram_addr, 32'd0);
    chk("rst_ram_data", ram_data, 32'd0);
    chk("rst_ram_wr", 32'(ram_wr), 32'd0);
    rst = 1'b0;
    wait_ready("sync_done");

    do_req("wr5", 1'b1, 32'd5, 32'hDEADBEEF, 2, 32'd0, 1'b0, 0);
    do_req("rd5", 1'b0, 32'd5, 32'd0, 2, 32'hDEADBEEF, 1'b0, 0);
    do_req("rd5_same", 1'b0, 32'd5, 32'd0, 2, 32'hDEADBEEF, 1'b0, 5);
    do_req("oob1024", 1'b0, 32'd1024, 32'd0, 1, 32'd0, 1'b1, 0);
    chk("oob_ram_addr", ram_addr, 32'd5);
    do_req("oob_big", 1'b1, 32'hFFFF_FFFF, 32'h1111_2222, 1, 32'd0, 1'b1, 0);
    chk("oob_ram_wr", 32'(ram_wr), 32'd0);
    do_req("wr1023", 1'b1, 32'd1023, 32'h0BAD_F00D, 2, 32'd0, 1'b0, 0);
    do_req("wr1023_same", 1'b1, 32'd1023, 32'h0BAD_F00D, 2, 32'd0, 1'b0, 0);
    do_req("rd1023", 1'b0, 32'd1023, 32'd0, 2, 32'h0BAD_F00D, 1'b0, 0);
    do_req("rd5_again", 1'b0, 32'd5, 32'd0, 2, 32'hDEADBEEF, 1'b0, 0);

    // Reset lands in WAIT_HIGH, before the executing negedge of the write.
    chk("wh_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_addr  = 32'd7;
    req_wdata = 32'h1234_5678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("wh_drive_addr", ram_addr, 32'd7);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("wh_rst_ram_addr", ram_addr, 32'd0);
    chk("wh_rst_ram_data", ram_data, 32'd0);
    chk("wh_rst_ram_wr", 32'(ram_wr), 32'd0);
    chk("wh_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("wh_rst_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_ready("wh_sync_done");
    do_req("rd7_after_rst", 1'b0, 32'd7, 32'd0, 2, 32'd0, 1'b0, 0);
    do_req("rd5_after_rst", 1'b0, 32'd5, 32'd0, 2, 32'hDEADBEEF, 1'b0, 0);

`ifdef MEM_CTRL_TIMEOUT_EN
    tie_hi = 1'b1;
    do_req("timeout", 1'b1, 32'd11, 32'h0000_0001, 64, 32'd0, 1'b1, 0);
    chk("timeout_to_sync", 32'(req_ready), 32'd0);
    tie_hi = 1'b0;
    wait_ready("timeout_sync_done");
    do_req("rd5_after_to", 1'b0, 32'd5, 32'd0, 2, 32'hDEADBEEF, 1'b0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
